// File: rtl/serial_pkg.sv
// Shared definitions for the serial link (transmit serializer and receive shift register).
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: loads a WIDTH-bit word on a valid/ready
// handshake and emits it one bit per shift_en, MSB-first or LSB-first.
module piso_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             dir,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done,
  output ser_state_e       state_dbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  ser_state_e       state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             dir_q;

  // Load handshake: a word transfers on a rising edge where load_valid && load_ready;
  // load_ready depends only on state, and upstream holds load_data until then.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
      dir_q <= DIR_MSB_FIRST;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_valid) begin
            sreg  <= load_data;
            dir_q <= dir;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (shift_en) begin
            if (cnt == LAST) begin
              state <= IDLE;
              sreg  <= '0;
              cnt   <= '0;
              done  <= 1'b1;
            end else begin
              // Move the next bit toward whichever end drives sout, zero-filling.
              if (dir_q == DIR_LSB_FIRST) sreg <= {1'b0, sreg[WIDTH-1:1]};
              else                        sreg <= {sreg[WIDTH-2:0], 1'b0};
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign load_ready = (state == IDLE);
  assign busy       = (state == SHIFT);
  assign sout_valid = (state == SHIFT);
  assign sout       = (state == SHIFT) &&
                      ((dir_q == DIR_LSB_FIRST) ? sreg[0] : sreg[WIDTH-1]);
  assign state_dbg  = state;

endmodule
